// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel front end: image geometry
// defaults, pixel width and the column buffer fill/run states.
package sobel_pkg;

   localparam int IMG_WIDTH_DEF  = 720;
   localparam int IMG_HEIGHT_DEF = 540;
   localparam int PIX_WIDTH      = 8;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Address width able to index n entries, never narrower than 1 bit.
   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory with registered, enabled read port.
// Written so that synthesis maps it onto a block RAM.
module line_ram
   import sobel_pkg::*;
#(
   parameter int DEPTH = IMG_WIDTH_DEF,
   parameter int WIDTH = 2 * PIX_WIDTH,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store one column word per enabled cycle.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Read port: one-cycle latency, output held while rd_en is low.
   always_ff @(posedge clock) begin
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/column_buffer.sv
// Turns a raster pixel stream into 3-row columns for the sobel stage:
// one line RAM keeps rows y-1 and y-2, shifted up as row y streams in.
module column_buffer
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int DWIDTH_IN  = PIX_WIDTH,
   parameter int DWIDTH_OUT = 3 * PIX_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  fifo_in_rd_en,
   input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
   input  logic                  fifo_in_empty,
   output logic                  fifo_out_wr_en,
   output logic [DWIDTH_OUT-1:0] fifo_out_din,
   input  logic                  fifo_out_full
);

   localparam int CW = addr_w(IMG_WIDTH);
   localparam int RW = addr_w(IMG_HEIGHT);
   localparam int LW = 2 * DWIDTH_IN;

   state_t state;
   state_t state_nxt;

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic                 col_last;
   logic                 row_last;

   logic                 s2_valid;
   logic                 s2_emit;
   logic [DWIDTH_IN-1:0] s2_pix;
   logic [CW-1:0]        s2_col;

   logic                 accept;
   logic                 s2_go;
   logic                 s2_adv;
   logic [LW-1:0]        rd_data;
   logic [LW-1:0]        wr_data;

   assign col_last = (col == CW'(IMG_WIDTH - 1));
   assign row_last = (row == RW'(IMG_HEIGHT - 1));

   // Handshake: S2 moves unless it must emit into a full FIFO;
   // S1 loads whenever S2 is free or leaving this cycle.
   always_comb begin
      s2_go          = !s2_emit || !fifo_out_full;
      s2_adv         = !reset && s2_valid && s2_go;
      accept         = !reset && !fifo_in_empty && (!s2_valid || s2_go);
      fifo_in_rd_en  = accept;
      fifo_out_wr_en = !reset && s2_valid && s2_emit && !fifo_out_full;
      fifo_out_din   = DWIDTH_OUT'({s2_pix, rd_data});
      wr_data        = {s2_pix, rd_data[LW-1:DWIDTH_IN]};
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= FILL;
      else
         state <= state_nxt;
   end

   // Next state: leave FILL after row 1, return at the frame's end.
   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL:
            if (accept && col_last && row == RW'(1))
               state_nxt = RUN;
         RUN:
            if (accept && col_last && row_last)
               state_nxt = FILL;
         default:
            state_nxt = FILL;
      endcase
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // S2 occupancy and emit flag; emit is fixed at accept time.
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_emit  <= 1'b0;
      end else if (accept) begin
         s2_valid <= 1'b1;
         s2_emit  <= (state == RUN);
      end else if (s2_go) begin
         s2_valid <= 1'b0;
         s2_emit  <= 1'b0;
      end
   end

   // S2 data payload; only meaningful while s2_valid is set.
   always_ff @(posedge clock) begin
      if (accept) begin
         s2_pix <= fifo_in_dout;
         s2_col <= col;
      end
   end

   line_ram #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (LW),
      .AW    (CW)
   ) u_line_ram (
      .clock   (clock),
      .wr_en   (s2_adv),
      .wr_addr (s2_col),
      .wr_data (wr_data),
      .rd_en   (accept),
      .rd_addr (col),
      .rd_data (rd_data)
   );

endmodule

// File: doc/column_buffer.md
COLUMN_BUFFER -- requirements
Module: column_buffer

Interface
REQ-001 Parameter IMG_WIDTH, 720, pixels per row; legal range 2 or more.
REQ-002 Parameter IMG_HEIGHT, 540, rows per frame; legal range 3 or more.
REQ-003 Parameter DWIDTH_IN, 8, grayscale pixel width.
REQ-004 Parameter DWIDTH_OUT, 24, output column word width (3 x DWIDTH_IN).
REQ-005 Port clock: input, 1 bit, the only clock; rising edge.
REQ-006 Port reset: input, 1 bit, synchronous, active-high.
REQ-007 Port fifo_in_rd_en: output, 1 bit, pops the upstream FWFT FIFO.
REQ-008 Port fifo_in_dout: input, DWIDTH_IN bits, raster-order pixel; valid whenever fifo_in_empty=0.
REQ-009 Port fifo_in_empty: input, 1 bit, upstream FIFO empty.
REQ-010 Port fifo_out_wr_en: output, 1 bit, pushes fifo_out_din into the downstream FIFO (sobel input).
REQ-011 Port fifo_out_din: output, DWIDTH_OUT bits, {row y [23:16], row y-1 [15:8], row y-2 [7:0]}, all at column x.
REQ-012 Port fifo_out_full: input, 1 bit, downstream FIFO full.

Function
REQ-013 Two-stage pipeline: S1 accepts a pixel and issues a line-RAM read at address col; S2 holds the pixel plus the RAM data and writes the output.
REQ-014 Line RAM: 16 bits x IMG_WIDTH; [15:8] holds row y-1 and [7:0] holds row y-2 for each column.
REQ-015 When S2 advances, it writes {S2 pixel, rd_data[15:8]} back to the RAM at S2's column, which shifts that column up by one row.
REQ-016 RAM read enable is asserted only on S1 accept, so rd_data stays stable while S2 stalls.
REQ-017 fifo_in_rd_en = !fifo_in_empty && (!s2_valid || s2_go), computed combinationally.
REQ-018 s2_go = !s2_emit || !fifo_out_full; s2_emit is captured from the state at S1 accept.
REQ-019 fifo_out_wr_en = s2_valid && s2_emit && !fifo_out_full, computed combinationally.
REQ-020 fifo_out_din = {s2_pix, rd_data[15:8], rd_data[7:0]}.
REQ-021 Throughput is 1 pixel/cycle with no stalls; S2 drains and S1 loads in the same cycle.
REQ-022 Latency: a pixel popped at cycle t produces its output at cycle t+1 when fifo_out_full=0.
REQ-023 Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on S1 accept; col wraps to 0 and increments row; row wraps to 0 after pixel (W-1, H-1).
REQ-024 FSM states FILL and RUN.
REQ-025 FILL (rows 0-1): pixels are accepted and written to the RAM with s2_emit=0, so nothing is output.
REQ-026 FILL to RUN: on accept of pixel (W-1, 1).
REQ-027 RUN to FILL: on accept of pixel (W-1, H-1), for the next frame.
REQ-028 Each frame yields exactly IMG_WIDTH x (IMG_HEIGHT-2) outputs, in raster order.
REQ-029 fifo_in_empty=1: no pop, counters hold, and S2 still drains.
REQ-030 fifo_out_full=1 with s2_emit=1: S2 holds, fifo_in_rd_en=0, and fifo_out_din stays stable.
REQ-031 fifo_out_full has no effect while in FILL.

Reset
REQ-032 Reset sets col=0, row=0, state=FILL, s2_valid=0 and s2_emit=0.
REQ-033 Reset forces fifo_in_rd_en=0 and fifo_out_wr_en=0 in the same cycle; fifo_out_din is don't-care while fifo_out_wr_en=0.
REQ-034 Reset in mid-frame abandons the frame; the next pixel accepted is treated as (0,0).
REQ-035 RAM contents are not reset; FILL overwrites them before any output uses them.

Structure
REQ-036 Shared package sobel_pkg holds the IMG_WIDTH and IMG_HEIGHT defaults, the pixel-width constant, and the FILL/RUN state encoding.
REQ-037 Sub-module line_ram: simple dual-port, synchronous read with read enable, 1-cycle latency, parameterised depth and width, inferable as BRAM.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 16*row + col, FIFOs never empty/full unless stated)
REQ-038 Streaming frame -> first wr_en on the cycle after pixel (0,2) is popped, din=0x201000; last din=0x332313; exactly 8 writes.
REQ-039 fifo_out_full held 5 cycles at output (1,2) -> rd_en=0 and din=0x211101 stable throughout; no loss or duplicate after release.
REQ-040 fifo_in_empty toggled every other cycle -> same 8 words in order, and wr_en never asserts without a preceding pop.
REQ-041 Two back-to-back frames (second frame = pixel + 0x80) -> 16 writes; second frame's first din=0xA09080, with no first-frame data in it.
REQ-042 Reset after pixel (2,2), then a fresh frame -> no writes until pixel (0,2) of the new frame, then the same 8 words as REQ-038.
